// File: rtl/decode_byte_queue.sv
`default_nettype none
// ============================================================================
// Module   : decode_byte_queue
// Brief    : Circular instruction byte queue feeding the decode stage. Takes
//            fixed-size fetch chunks, presents a byte-0-first window plus its
//            PC, dequeues the bytes the decoder consumed, flushes on redirect.
// Revision : 1.0 - initial release
// ============================================================================
module decode_byte_queue #(
    parameter int DEPTH_BYTES  = 32,
    parameter int FETCH_BYTES  = 8,
    parameter int WINDOW_BYTES = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [63:0]                 flush_pc,
    input  logic                        fetch_valid,
    output logic                        fetch_ready,
    input  logic [FETCH_BYTES*8-1:0]    fetch_data,
    output logic [0:WINDOW_BYTES*8-1]   window_data,
    output logic [4:0]                  window_count,
    output logic [63:0]                 window_pc,
    input  logic                        consume_valid,
    input  logic [4:0]                  consume_count,
    output logic                        overrun
);

    localparam int c_PTR_W = $clog2(DEPTH_BYTES);
    localparam int c_CNT_W = $clog2(DEPTH_BYTES + 1);

    // Highest occupancy at which a whole chunk still fits
    localparam logic [c_CNT_W-1:0] c_READY_MAX  = c_CNT_W'(DEPTH_BYTES - FETCH_BYTES);
    localparam logic [c_CNT_W-1:0] c_FETCH_CNT  = c_CNT_W'(FETCH_BYTES);
    localparam logic [c_CNT_W-1:0] c_WINDOW_CNT = c_CNT_W'(WINDOW_BYTES);
    localparam logic [c_PTR_W-1:0] c_FETCH_PTR  = c_PTR_W'(FETCH_BYTES);

    // Byte storage; contents are don't-care until written, so never reset
    logic [7:0]         r_mem [0:DEPTH_BYTES-1];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic [63:0]        r_pc;
    logic               r_overrun;

    logic               w_enq;
    logic               w_deq;
    logic               w_bad_consume;
    logic [4:0]         w_window_count;
    logic [c_CNT_W-1:0] w_enq_amt;
    logic [c_CNT_W-1:0] w_deq_amt;

    // Acceptance looks only at current occupancy, never at a same-cycle consume
    assign fetch_ready = (r_count <= c_READY_MAX) && !reset && !flush;
    assign w_enq       = fetch_valid && fetch_ready;

    // Window size is occupancy clipped to the window width
    always_comb begin
        w_window_count = r_count[4:0];
        if (r_count > c_WINDOW_CNT) begin
            w_window_count = 5'(WINDOW_BYTES);
        end
    end

    // A consume is legal only for a nonzero length that lies inside the window
    assign w_deq         = consume_valid && (consume_count != 5'd0) &&
                           (consume_count <= w_window_count);
    assign w_bad_consume = consume_valid && !w_deq;

    assign w_enq_amt = w_enq ? c_FETCH_CNT : '0;
    assign w_deq_amt = w_deq ? c_CNT_W'(consume_count) : '0;

    // Pointer, occupancy, PC and overrun state; reset beats flush beats traffic
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_pc      <= 64'd0;
            r_overrun <= 1'b0;
        end else if (flush) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_pc      <= flush_pc;
            r_overrun <= 1'b0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + c_FETCH_PTR;
            end
            if (w_deq) begin
                r_head <= r_head + c_PTR_W'(consume_count);
                r_pc   <= r_pc + 64'(consume_count);
            end
            r_count   <= r_count + w_enq_amt - w_deq_amt;
            r_overrun <= w_bad_consume;
        end
    end

    // Chunk write at the tail; pointer arithmetic wraps at the power-of-2 depth
    always_ff @(posedge clk) begin
        if (w_enq) begin
            for (int i = 0; i < FETCH_BYTES; i++) begin
                r_mem[r_tail + c_PTR_W'(i)] <= fetch_data[8*i +: 8];
            end
        end
    end

    // Window byte i comes from head+i; slots past the valid count read zero
    for (genvar gi = 0; gi < WINDOW_BYTES; gi++) begin : g_window
        localparam logic [c_PTR_W-1:0] c_OFS = c_PTR_W'(gi);
        localparam logic [c_CNT_W-1:0] c_POS = c_CNT_W'(gi);
        logic [c_PTR_W-1:0] w_idx;
        assign w_idx = r_head + c_OFS;
        assign window_data[8*gi +: 8] = (c_POS < r_count) ? r_mem[w_idx] : 8'h00;
    end

    assign window_count = w_window_count;
    assign window_pc    = r_pc;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_decode_byte_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_byte_queue
// Brief    : Self-checking bench for decode_byte_queue using a byte-stream
//            queue model, directed scenarios and a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_byte_queue;

    localparam int c_DEPTH  = 32;
    localparam int c_FETCH  = 8;
    localparam int c_WINDOW = 16;

    logic          clk;
    logic          reset;
    logic          flush;
    logic [63:0]   flush_pc;
    logic          fetch_valid;
    logic          fetch_ready;
    logic [63:0]   fetch_data;
    logic [0:127]  window_data;
    logic [4:0]    window_count;
    logic [63:0]   window_pc;
    logic          consume_valid;
    logic [4:0]    consume_count;
    logic          overrun;

    int total = 0;
    int bad   = 0;

    // Reference model: the queued byte stream in address order
    byte unsigned mq [$];
    logic [63:0]  mpc;
    logic         mov;

    decode_byte_queue #(
        .DEPTH_BYTES (c_DEPTH),
        .FETCH_BYTES (c_FETCH),
        .WINDOW_BYTES(c_WINDOW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .fetch_data   (fetch_data),
        .window_data  (window_data),
        .window_count (window_count),
        .window_pc    (window_pc),
        .consume_valid(consume_valid),
        .consume_count(consume_count),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int model_wc();
        return (mq.size() < c_WINDOW) ? mq.size() : c_WINDOW;
    endfunction

    task automatic check_outputs();
        logic [0:127] ew;
        ew = '0;
        for (int i = 0; i < c_WINDOW; i++) begin
            if (i < mq.size()) ew[8*i +: 8] = mq[i];
        end
        chk("window_count", 128'(window_count), 128'(model_wc()));
        chk("window_pc",    128'(window_pc),    128'(mpc));
        chk("window_data",  window_data,        ew);
        chk("overrun",      128'(overrun),      128'(mov));
    endtask

    // One clock cycle: apply inputs, check ready, advance model, check outputs
    task automatic cyc(input logic fv, input logic [63:0] fd, input logic cv,
                       input logic [4:0] cc, input logic fl, input logic [63:0] fpc,
                       input logic rst);
        logic exp_ready;
        logic acc;
        int   wc;
        fetch_valid   = fv;
        fetch_data    = fd;
        consume_valid = cv;
        consume_count = cc;
        flush         = fl;
        flush_pc      = fpc;
        reset         = rst;
        #1;
        exp_ready = (mq.size() <= c_DEPTH - c_FETCH) && !rst && !fl;
        chk("fetch_ready", 128'(fetch_ready), 128'(exp_ready));
        acc = fv && exp_ready;
        wc  = model_wc();
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mpc = 64'd0;
            mov = 1'b0;
        end else if (fl) begin
            mq.delete();
            mpc = fpc;
            mov = 1'b0;
        end else begin
            mov = 1'b0;
            if (cv) begin
                if (cc == 0 || int'(cc) > wc) begin
                    mov = 1'b1;
                end else begin
                    for (int k = 0; k < int'(cc); k++) void'(mq.pop_front());
                    mpc = mpc + 64'(cc);
                end
            end
            if (acc) begin
                for (int k = 0; k < c_FETCH; k++) mq.push_back(fd[8*k +: 8]);
            end
        end
        #1;
        check_outputs();
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic idle();
        cyc(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 64'd0, 1'b0);
    endtask

    task automatic enq(input logic [63:0] fd);
        cyc(1'b1, fd, 1'b0, 5'd0, 1'b0, 64'd0, 1'b0);
    endtask

    task automatic do_flush(input logic [63:0] fpc);
        cyc(1'b0, 64'd0, 1'b0, 5'd0, 1'b1, fpc, 1'b0);
    endtask

    initial begin
        mpc = 64'd0;
        mov = 1'b0;

        // Reset held two cycles, then first idle cycle out of reset
        cyc(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 64'd0, 1'b1);
        cyc(1'b1, rnd64(), 1'b1, 5'd3, 1'b0, 64'd0, 1'b1);
        idle();

        // Single chunk 48 89 E5 90 90 90 90 90
        enq(64'h9090_9090_90E5_8948);
        idle();

        // Redirect, three chunks, consume three, then keep fetching into backpressure
        do_flush(64'h0000_0000_0040_0000);
        for (int n = 0; n < 3; n++) enq(rnd64());
        cyc(1'b0, 64'd0, 1'b1, 5'd3, 1'b0, 64'd0, 1'b0);
        for (int n = 0; n < 3; n++) enq(64'h1122_3344_5566_7788);
        for (int n = 0; n < 4; n++) cyc(1'b1, 64'hA0A1_A2A3_A4A5_A6A7, 1'b1, 5'd4, 1'b0, 64'd0, 1'b0);

        // Fill to capacity, then stream consumes of 5 across the buffer wrap
        do_flush(64'h0000_0000_0000_1000);
        for (int n = 0; n < 4; n++) enq(rnd64());
        for (int n = 0; n < 16; n++) cyc(1'b1, rnd64(), 1'b1, 5'd5, 1'b0, 64'd0, 1'b0);

        // Simultaneous enqueue and consume at occupancy 16
        do_flush(64'h0000_0000_0000_2000);
        enq(rnd64());
        enq(rnd64());
        cyc(1'b1, rnd64(), 1'b1, 5'd7, 1'b0, 64'd0, 1'b0);

        // Consume past the window, then a zero-length consume
        do_flush(64'hFFFF_FFFF_FFFF_FFFC);
        enq(rnd64());
        cyc(1'b0, 64'd0, 1'b1, 5'd9, 1'b0, 64'd0, 1'b0);
        idle();
        cyc(1'b0, 64'd0, 1'b1, 5'd0, 1'b0, 64'd0, 1'b0);
        cyc(1'b0, 64'd0, 1'b1, 5'd6, 1'b0, 64'd0, 1'b0);

        // Flush racing a fetch and a consume
        enq(rnd64());
        cyc(1'b1, rnd64(), 1'b1, 5'd2, 1'b1, 64'h0000_7FFF_0000_0010, 1'b0);
        idle();

        // Reset in the middle of traffic
        enq(rnd64());
        enq(rnd64());
        cyc(1'b1, rnd64(), 1'b1, 5'd1, 1'b1, 64'h1234, 1'b1);
        idle();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic       fv;
            logic       cv;
            logic [4:0] cc;
            logic       fl;
            int         wc;
            int         lim;
            wc  = model_wc();
            fv  = ($urandom_range(0, 3) != 0);
            cv  = ($urandom_range(0, 2) != 0);
            lim = (wc < 15) ? wc : 15;
            if ($urandom_range(0, 9) == 0 || lim == 0) begin
                cc = 5'($urandom_range(0, 16));
            end else begin
                cc = 5'($urandom_range(1, lim));
            end
            fl = ($urandom_range(0, 49) == 0);
            cyc(fv, rnd64(), cv, cc, fl, rnd64(), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
